// File: rtl/gpio_pinmux_pkg.sv
// gpio_pinmux_pkg
//   Shared definitions for the GPIO pad multiplexer: bit positions inside the
//   per-pad configuration byte, the function-select width, the pad config
//   struct and a helper that packs the struct into the byte seen on reads.
package gpio_pinmux_pkg;

    localparam int FSEL_LSB = 0;
    localparam int FSEL_W   = 2;
    localparam int OD_BIT   = 2;
    localparam int INV_BIT  = 3;
    localparam int RISE_BIT = 4;
    localparam int FALL_BIT = 5;
    localparam int EVT_BIT  = 7;

    typedef struct packed {
        logic              evt;      // sticky edge event
        logic              fall_en;
        logic              rise_en;
        logic              inv;
        logic              od;       // open-drain emulation
        logic [FSEL_W-1:0] fsel;
    } pad_cfg_t;

    // Byte layout as returned on reads; bit 6 is reserved and reads 0.
    function automatic logic [7:0] cfg_to_byte(input pad_cfg_t c);
        logic [7:0] b;
        b                         = '0;
        b[FSEL_LSB +: FSEL_W]     = c.fsel;
        b[OD_BIT]                 = c.od;
        b[INV_BIT]                = c.inv;
        b[RISE_BIT]               = c.rise_en;
        b[FALL_BIT]               = c.fall_en;
        b[EVT_BIT]                = c.evt;
        return b;
    endfunction

endpackage

// File: rtl/gpio_pinmux_pad.sv
// gpio_pinmux_pad
//   One pad slice: configuration register, function output mux with a
//   registered pad_out/pad_oeb stage (push-pull or open-drain), 2-FF input
//   synchroniser with optional inversion, edge detector and sticky event.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   we, wdata       write strobe already decoded for this pad, write byte
//   fn_o, fn_oe     per-function output value / enable for this pad
//   fn_i            per-function input value (only the selected one is live)
//   pad_in          raw pad input
//   pad_out,pad_oeb registered pad output / active-low output enable
//   cfg_byte        current config byte for the read mux
//   evt             sticky event bit, for the interrupt OR
module gpio_pinmux_pad
    import gpio_pinmux_pkg::*;
#(
    parameter int NFUNC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [7:0]       wdata,
    input  logic [NFUNC-1:0] fn_o,
    input  logic [NFUNC-1:0] fn_oe,
    output logic [NFUNC-1:0] fn_i,
    input  logic             pad_in,
    output logic             pad_out,
    output logic             pad_oeb,
    output logic [7:0]       cfg_byte,
    output logic             evt
);

    pad_cfg_t cfg_q, cfg_d;
    logic     sync1_q, sync1_d;
    logic     sync2_q, sync2_d;
    logic     s_prev_q, s_prev_d;
    logic     pad_out_q, pad_out_d;
    logic     pad_oeb_q, pad_oeb_d;

    logic     sel_o, sel_oe, sel_valid;
    logic     s, rise, fall;
    logic     rsvd_unused;

    // Bit 6 of the write byte is reserved and has no storage.
    assign rsvd_unused = wdata[6];

    // Function select; fsel values at or above NFUNC leave sel_valid low.
    always_comb begin
        sel_o     = 1'b0;
        sel_oe    = 1'b0;
        sel_valid = 1'b0;
        for (int f = 0; f < NFUNC; f++) begin
            if (cfg_q.fsel == FSEL_W'(f)) begin
                sel_o     = fn_o[f];
                sel_oe    = fn_oe[f];
                sel_valid = 1'b1;
            end
        end
    end

    // Synchronised, optionally inverted input. Because inv is applied after
    // the synchroniser, toggling inv is seen as an edge by the detector.
    assign s    = sync2_q ^ cfg_q.inv;
    assign rise = s & ~s_prev_q;
    assign fall = ~s & s_prev_q;

    always_comb begin
        fn_i = '0;
        for (int f = 0; f < NFUNC; f++) begin
            if (cfg_q.fsel == FSEL_W'(f)) begin
                fn_i[f] = s;
            end
        end
    end

    always_comb begin
        cfg_d = cfg_q;
        if (we) begin
            cfg_d.fsel    = wdata[FSEL_LSB +: FSEL_W];
            cfg_d.od      = wdata[OD_BIT];
            cfg_d.inv     = wdata[INV_BIT];
            cfg_d.rise_en = wdata[RISE_BIT];
            cfg_d.fall_en = wdata[FALL_BIT];
            if (wdata[EVT_BIT]) begin
                cfg_d.evt = 1'b0;
            end
        end
        // Evaluated after the clear so a coincident new event wins.
        if ((rise && cfg_q.rise_en) || (fall && cfg_q.fall_en)) begin
            cfg_d.evt = 1'b1;
        end
    end

    always_comb begin
        pad_out_d = 1'b0;
        pad_oeb_d = 1'b1;
        if (sel_valid) begin
            if (cfg_q.od) begin
                // Only ever drive low; a high level is left to the pull-up.
                pad_oeb_d = ~(sel_oe & ~sel_o);
            end else begin
                pad_out_d = sel_o;
                pad_oeb_d = ~sel_oe;
            end
        end
        sync1_d  = pad_in;
        sync2_d  = sync1_q;
        s_prev_d = s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q     <= '0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            s_prev_q  <= 1'b0;
            pad_out_q <= 1'b0;
            pad_oeb_q <= 1'b1;
        end else begin
            cfg_q     <= cfg_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            s_prev_q  <= s_prev_d;
            pad_out_q <= pad_out_d;
            pad_oeb_q <= pad_oeb_d;
        end
    end

    assign pad_out  = pad_out_q;
    assign pad_oeb  = pad_oeb_q;
    assign cfg_byte = cfg_to_byte(cfg_q);
    assign evt      = cfg_q.evt;

endmodule

// File: rtl/gpio_pinmux.sv
// gpio_pinmux
//   Run-time pad multiplexer between SoC peripherals and the GPIO ring.
//   NPADS pad slices, address decode for the byte-wide config port, a
//   registered read mux and the combined event interrupt.
// Config port: cfg_we / cfg_re are single-cycle strobes with no back-pressure;
//   a write lands at the clock edge where cfg_we is high, a read captures the
//   addressed byte (pre-write value when both strobes coincide) into cfg_rdata
//   at that edge and holds it until the next read. Addresses >= NPADS ignore
//   writes and read as 0.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   cfg_we, cfg_re, cfg_addr,
//   cfg_wdata, cfg_rdata         config register port
//   fn_o, fn_oe, fn_i            peripheral side, bit p*NFUNC+f
//   pad_in, pad_out, pad_oeb     pad ring side
//   irq                          OR of all sticky event bits
module gpio_pinmux
    import gpio_pinmux_pkg::*;
#(
    parameter int NPADS = 44,
    parameter int NFUNC = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_we,
    input  logic                   cfg_re,
    input  logic [5:0]             cfg_addr,
    input  logic [7:0]             cfg_wdata,
    output logic [7:0]             cfg_rdata,
    input  logic [NPADS*NFUNC-1:0] fn_o,
    input  logic [NPADS*NFUNC-1:0] fn_oe,
    output logic [NPADS*NFUNC-1:0] fn_i,
    input  logic [NPADS-1:0]       pad_in,
    output logic [NPADS-1:0]       pad_out,
    output logic [NPADS-1:0]       pad_oeb,
    output logic                   irq
);

    logic [NPADS-1:0] pad_we;
    logic [NPADS-1:0] evt_vec;
    logic [7:0]       cfg_byte [NPADS];
    logic [7:0]       rdata_q, rdata_d;

    for (genvar p = 0; p < NPADS; p++) begin : g_pad
        assign pad_we[p] = cfg_we && (cfg_addr == 6'(p));

        gpio_pinmux_pad #(
            .NFUNC (NFUNC)
        ) u_pad (
            .clk      (clk),
            .rst_n    (rst_n),
            .we       (pad_we[p]),
            .wdata    (cfg_wdata),
            .fn_o     (fn_o[p*NFUNC +: NFUNC]),
            .fn_oe    (fn_oe[p*NFUNC +: NFUNC]),
            .fn_i     (fn_i[p*NFUNC +: NFUNC]),
            .pad_in   (pad_in[p]),
            .pad_out  (pad_out[p]),
            .pad_oeb  (pad_oeb[p]),
            .cfg_byte (cfg_byte[p]),
            .evt      (evt_vec[p])
        );
    end

    // Unmatched addresses fall through to the zero default.
    always_comb begin
        rdata_d = rdata_q;
        if (cfg_re) begin
            rdata_d = '0;
            for (int p = 0; p < NPADS; p++) begin
                if (cfg_addr == 6'(p)) begin
                    rdata_d = cfg_byte[p];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign cfg_rdata = rdata_q;
    assign irq       = |evt_vec;

endmodule

// File: doc/gpio_pinmux.md
# gpio_pinmux

Parametrised pad multiplexer between the SoC peripherals and the openframe GPIO ring. Each of NPADS pads is routed at run time to one of NFUNC peripheral functions, with registered outputs, optional open-drain emulation, 2-FF input synchronisation, optional input inversion and per-pad edge-event capture with a combined interrupt. It replaces the fixed pin assignment used so far and is configured through a simple byte-wide register port.

## Interface
- NPADS, 44, number of pads (1..64)
- NFUNC, 4, functions per pad (1..4); function-select field is always 2 bits
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  config write strobe
- cfg_re  in  1  config read strobe
- cfg_addr  in  6  pad index
- cfg_wdata  in  8  write data
- cfg_rdata  out  8  read data, registered
- fn_o  in  NPADS*NFUNC  function output values, bit p*NFUNC+f
- fn_oe  in  NPADS*NFUNC  function output enables, active high
- fn_i  out  NPADS*NFUNC  function input values
- pad_in  in  NPADS  raw pad input
- pad_out  out  NPADS  pad output value
- pad_oeb  out  NPADS  pad output enable, active low
- irq  out  1  OR of all sticky event bits

## Operation
- Per-pad config byte: [1:0] fsel, [2] od, [3] inv, [4] rise_en, [5] fall_en, [6] reserved (reads 0), [7] evt (sticky; reads status, write 1 clears).
- fsel >= NFUNC: pad disabled, pad_oeb=1, pad_out=0, no fn_i bit driven.
- Push-pull (od=0): pad_out=fn_o[sel], pad_oeb=~fn_oe[sel].
- Open-drain (od=1): pad_out=0; pad_oeb=0 only when fn_oe[sel]=1 and fn_o[sel]=0, otherwise 1.
- Input: pad_in -> 2-FF sync -> XOR inv -> s. fn_i[p*NFUNC+fsel]=s; all other fn_i bits of that pad are 0.
- Edge detect on s against its previous value: rising with rise_en or falling with fall_en sets evt.
- W1C via cfg_wdata[7]=1; set and clear in the same cycle: set wins.
- Changing inv is itself an edge of s and may set evt when enabled.
- cfg_addr >= NPADS: writes ignored, reads return 0.
- cfg_we and cfg_re together: both performed; read returns the pre-write value.
- Reset: all config 0 (fsel 0, push-pull, no inversion, events off), pad_out=0, pad_oeb all 1, sync flops 0, fn_i 0, cfg_rdata 0, irq 0.

## Timing
- Output path: one register stage; fn_o/fn_oe at cycle N appear on pad_out/pad_oeb at N+1.
- Config write at edge N takes effect on outputs at N+2 (config register N, output register N+1).
- Input path: pad_in change sampled at edge N -> fn_i valid after edge N+1; evt set at edge N+2; irq asserted combinationally from evt (same cycle).
- Read: cfg_re at edge N -> cfg_rdata valid after N; held until the next read.
- Reset mid-operation clears everything asynchronously; the first events are possible 3 edges after deassertion.

## Structure
- Package gpio_pinmux_pkg: config bit positions (FSEL_LSB, OD_BIT, INV_BIT, RISE_BIT, FALL_BIT, EVT_BIT), FSEL_W=2, pad config struct typedef.
- Sub-module gpio_pinmux_pad: one pad slice (config register, output mux/register, sync, edge detect, sticky evt); the top-level generates NPADS instances plus address decode, read mux and irq OR.

## Test plan
- Reset, no writes: pad_oeb all 1 then pad 0 follows fn_o[0]/fn_oe[0] one cycle later; irq=0, cfg_rdata=0.
- Write pad 5 fsel=2, drive fn_o[22]=1, fn_oe[22]=1 -> pad_out[5]=1, pad_oeb[5]=0 two cycles after write; fsel=3 with NFUNC=3 -> pad_oeb[5]=1.
- Pad 9 od=1: fn_oe=1, fn_o=0 -> pad_oeb=0, pad_out=0; fn_o=1 -> pad_oeb=1.
- Pad 7 fsel=1 inv=1, pad_in[7] 0->1 -> fn_i[29]=0 after two edges, other fn_i bits of pad 7 remain 0.
- Pad 3 rise_en=1, pad_in 0->1 -> evt set at edge +3, irq=1; read addr 3 returns 0x90; W1C in the same cycle as a new edge -> evt stays 1; a plain W1C clears it and drops irq.
- Write/read addr 50 with NPADS=44 -> no state change, cfg_rdata=0; assert rst_n low mid-traffic -> all outputs return to reset values immediately.
